pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Architectural PC register and run-control FSM directly upstream of the single-cycle CPU core.
- Drives the core's pc_i every cycle and consumes the core's next-PC output and 6-bit interrupt vector.
- Decides per cycle whether the instruction commits, the PC advances, or the hart stops in HALT (EBREAK/ECALL) or TRAP (error).
- Provides commit_o, which integration uses to gate GPR and RAM write enables.

Parameters:
- DATA_WIDTH, 64, PC and counter width.
- RESET_PC, 64'h0, PC value after reset and after start_i.
- INTR_WIDTH, 6, width of the core interrupt vector.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- start_i  input  1  pulse: begin or restart execution at RESET_PC.
- resume_i  input  1  pulse: continue from HALT.
- new_pc_i  input  DATA_WIDTH  next PC computed by the core.
- interrupts_i  input  INTR_WIDTH  core vector. Bits: 0 FetchError, 1 DecodeError, 2 MemAccessError, 3 UnknownBrtyError, 4 ECALL, 5 EBREAK.
- pc_o  output  DATA_WIDTH  current PC, fed to the core's pc_i.
- commit_o  output  1  combinational: current instruction may write state.
- running_o  output  1  FSM in RUN.
- halted_o  output  1  FSM in HALT.
- trap_o  output  1  FSM in TRAP.
- cause_o  output  3  latched stop cause; 7 = none.
- epc_o  output  DATA_WIDTH  PC of the instruction that caused the stop.

Behaviour:
- Reset (async, rst_n_i low):
  - state = IDLE, pc_o = RESET_PC, cause_o = 7, epc_o = 0.
  - commit_o, running_o, halted_o and trap_o all 0.
  - Reset asserted mid-RUN discards the in-flight instruction immediately.
- States: IDLE, RUN, HALT, TRAP. Each flag output is a registered decode of the state.
- Stop-event priority, evaluated only in RUN, highest first:
  - bit0 -> cause 0.
  - bit1 -> cause 1.
  - bit2 -> cause 2.
  - bit3 -> cause 3.
  - misaligned new_pc_i (bits [1:0] != 0) -> cause 6.
  - bit4 -> cause 4.
  - bit5 -> cause 5.
- commit_o:
  - = RUN && interrupts_i[3:0] == 0 && new_pc_i[1:0] == 0 && !interrupts_i[4] && !interrupts_i[5].
  - Combinational, zero latency.
- IDLE:
  - start_i -> RUN; pc_o stays RESET_PC. resume_i is ignored.
- RUN, no stop event:
  - pc_o <= new_pc_i at each edge. One instruction per cycle.
- RUN, error event (causes 0-3, 6):
  - -> TRAP. pc_o holds. cause_o and epc_o latch the cause and the current pc_o.
- RUN, ECALL or EBREAK:
  - -> HALT. pc_o holds. cause_o = 4 or 5, epc_o = pc_o.
- RUN, start_i asserted:
  - Ignored.
- HALT:
  - resume_i -> RUN with pc_o <= epc_o + 4; cause_o <= 7.
  - start_i -> RUN with pc_o <= RESET_PC; cause_o <= 7.
  - start_i and resume_i together: start_i wins.
- TRAP:
  - resume_i is ignored; only start_i leaves TRAP (RUN, pc_o = RESET_PC, cause_o = 7).
  - epc_o holds until the next stop.
- Arithmetic:
  - epc_o + 4 wraps modulo 2^DATA_WIDTH.
  - No PC arithmetic beyond that; the next PC comes entirely from the core.
- Interrupt inputs arriving outside RUN are ignored.

Optional Feature:
- Macro: PC_SEQ_COUNTERS_EN.
- When defined:
  - Adds outputs cycle_cnt_o and instret_o, each DATA_WIDTH wide. Both reset to 0.
  - cycle_cnt_o increments every cycle in RUN.
  - instret_o increments on every cycle with commit_o = 1.
  - Both wrap at 2^DATA_WIDTH and hold in IDLE, HALT and TRAP.
  - Both clear on start_i when it is accepted.
- When undefined: the outputs and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then start_i; new_pc_i = pc_o + 4 for 3 cycles -> pc_o sequence 0x0, 0x4, 0x8, 0xC; commit_o = 1 each cycle; running_o = 1.
- In RUN at pc 0x10, interrupts_i = 6'b100000 (EBREAK) -> HALT, cause_o = 5, epc_o = 0x10, commit_o = 0 that cycle; resume_i -> RUN, pc_o = 0x14, cause_o = 7.
- In RUN at pc 0x20, interrupts_i = 6'b010101 -> TRAP with cause_o = 0 (priority), epc_o = 0x20; resume_i ignored; start_i -> RUN, pc_o = 0x0.
- In RUN at pc 0x8, new_pc_i = 0x1A and interrupts_i = 0 -> TRAP, cause_o = 6, pc_o holds 0x8, commit_o = 0.
- rst_n_i pulsed low mid-cycle during RUN at pc 0x40 -> outputs return to reset values immediately, without waiting for a clock edge; start_i and resume_i together in HALT -> restart at RESET_PC.
- With PC_SEQ_COUNTERS_EN: 5 RUN cycles, of which the 5th is ECALL -> cycle_cnt_o = 5, instret_o = 4; both hold in HALT; clear to 0 on the following start_i.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Architectural PC register and run-control FSM sitting directly in front of
// a single-cycle CPU core. Every cycle it presents pc_o to the core, looks at
// the core's next-PC and interrupt vector, and decides whether the current
// instruction commits, the PC advances, or the hart stops in HALT
// (ECALL/EBREAK) or TRAP (error).
//
// Optional build macro: PC_SEQ_COUNTERS_EN
//   Adds cycle_cnt_o / instret_o performance counters.
//
// Ports:
//   clk_i         in   clock, rising edge
//   rst_n_i       in   asynchronous active-low reset
//   start_i       in   pulse: (re)start execution at RESET_PC
//   resume_i      in   pulse: continue from HALT at epc_o + 4
//   new_pc_i      in   next PC computed by the core
//   interrupts_i  in   core event vector
//                      [0] FetchError [1] DecodeError [2] MemAccessError
//                      [3] UnknownBrtyError [4] ECALL [5] EBREAK
//   pc_o          out  current PC (drives the core's pc_i)
//   commit_o      out  combinational: current instruction may write state
//   running_o     out  FSM in RUN  (registered)
//   halted_o      out  FSM in HALT (registered)
//   trap_o        out  FSM in TRAP (registered)
//   cause_o       out  latched stop cause, 7 = none
//   epc_o         out  PC of the instruction that caused the last stop
//   cycle_cnt_o   out  (PC_SEQ_COUNTERS_EN) cycles spent in RUN
//   instret_o     out  (PC_SEQ_COUNTERS_EN) committed instructions
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    INTR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  resume_i,
  input  logic [DATA_WIDTH-1:0] new_pc_i,
  input  logic [INTR_WIDTH-1:0] interrupts_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  commit_o,
  output logic                  running_o,
  output logic                  halted_o,
  output logic                  trap_o,
  output logic [2:0]            cause_o,
  output logic [DATA_WIDTH-1:0] epc_o
`ifdef PC_SEQ_COUNTERS_EN
  ,
  output logic [DATA_WIDTH-1:0] cycle_cnt_o,
  output logic [DATA_WIDTH-1:0] instret_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  localparam logic [2:0] CAUSE_NONE = 3'd7;
  localparam logic [2:0] CAUSE_MISA = 3'd6;
  localparam logic [2:0] CAUSE_ECALL = 3'd4;
  localparam logic [2:0] CAUSE_EBRK = 3'd5;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_epc;
  logic [2:0]            r_cause;
  logic                  r_running;
  logic                  r_halted;
  logic                  r_trap;

  logic [2:0]            w_cause;
  logic                  w_is_halt;
  logic                  w_commit;

  // Misalignment sits between the hard errors and ECALL/EBREAK: a bad
  // next-PC is a fault even when the instruction is also an environment call.
  function automatic logic [2:0] stop_cause(input logic [INTR_WIDTH-1:0] intr,
                                            input logic [1:0]            npc_lsb);
    if (intr[0])             return 3'd0;
    else if (intr[1])        return 3'd1;
    else if (intr[2])        return 3'd2;
    else if (intr[3])        return 3'd3;
    else if (npc_lsb != 2'b0) return CAUSE_MISA;
    else if (intr[4])        return CAUSE_ECALL;
    else if (intr[5])        return CAUSE_EBRK;
    else                     return CAUSE_NONE;
  endfunction

  assign w_cause   = stop_cause(interrupts_i, new_pc_i[1:0]);
  assign w_is_halt = (w_cause == CAUSE_ECALL) || (w_cause == CAUSE_EBRK);
  // State decode uses r_state directly so an async reset kills commit at once.
  assign w_commit  = (r_state == S_RUN) && (w_cause == CAUSE_NONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_epc     <= '0;
      r_cause   <= CAUSE_NONE;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      r_trap    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_PC;
            r_cause   <= CAUSE_NONE;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_cause == CAUSE_NONE) begin
            r_pc <= new_pc_i;
          end else begin
            // PC holds on the faulting/stopping instruction.
            r_epc     <= r_pc;
            r_cause   <= w_cause;
            r_running <= 1'b0;
            if (w_is_halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_TRAP;
              r_trap  <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (start_i) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_PC;
            r_cause   <= CAUSE_NONE;
            r_running <= 1'b1;
            r_halted  <= 1'b0;
          end else if (resume_i) begin
            r_state   <= S_RUN;
            r_pc      <= r_epc + DATA_WIDTH'(4);
            r_cause   <= CAUSE_NONE;
            r_running <= 1'b1;
            r_halted  <= 1'b0;
          end
        end
        S_TRAP: begin
          if (start_i) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_PC;
            r_cause   <= CAUSE_NONE;
            r_running <= 1'b1;
            r_trap    <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
          r_trap    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQ_COUNTERS_EN
  logic [DATA_WIDTH-1:0] r_cycle_cnt;
  logic [DATA_WIDTH-1:0] r_instret;
  logic                  w_start_acc;

  // start_i is accepted in every state except RUN.
  assign w_start_acc = start_i && (r_state != S_RUN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else if (w_start_acc) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else if (r_state == S_RUN) begin
      r_cycle_cnt <= r_cycle_cnt + DATA_WIDTH'(1);
      if (w_commit) begin
        r_instret <= r_instret + DATA_WIDTH'(1);
      end
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
  assign instret_o   = r_instret;
`endif

  assign pc_o      = r_pc;
  assign commit_o  = w_commit;
  assign running_o = r_running;
  assign halted_o  = r_halted;
  assign trap_o    = r_trap;
  assign cause_o   = r_cause;
  assign epc_o     = r_epc;

endmodule
